// File: rtl/fm_mem_responder.sv
// Memory responder for the 3D core master port, backed by an internal word RAM; one command at a time.
// Write beats are acked from the cycle after the request. Read data streams RD_LATENCY cycles after the command ack.
module fm_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_adrs,
  input  logic [2:0]  i_len,
  output logic        o_ack,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_dbw,
  output logic        o_strr,
  output logic [31:0] o_dbr,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ACK, RD_WAIT, RD_STREAM} state_t;

  localparam int WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        wait_q, wait_d;
  logic              ack_q, ack_d;
  logic              strr_q, strr_d;
  logic              busy_q, busy_d;
  logic [31:0]       dbr_q, dbr_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] rd_adr;
  logic              unused_adrs;

  assign unused_adrs = ^{i_adrs[31:ADDR_W+2], i_adrs[1:0]};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    ack_d   = ack_q;
    strr_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          adr_d   = i_adrs[ADDR_W+1:2];
          len_d   = i_len;
          beat_d  = '0;
          wait_d  = '0;
          ack_d   = 1'b1;
          state_d = i_wr ? WRITE : RD_ACK;
        end
      end
      WRITE: begin
        // A cycle without i_req is a stall: ack stays up, nothing is written.
        if (i_req) begin
          wr_en = 1'b1;
          if (beat_q == len_q) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      RD_ACK: begin
        ack_d = 1'b0;
        if (RD_LATENCY == 1) begin
          state_d = RD_STREAM;
          strr_d  = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_q == 3'(WAIT_LAST)) begin
          state_d = RD_STREAM;
          strr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      RD_STREAM: begin
        if (beat_q == len_q) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
          strr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM read lands directly in the output register, so o_dbr is zero between beats.
  assign wr_adr = adr_q + ADDR_W'(beat_q);
  assign rd_adr = adr_q + ADDR_W'(beat_d);
  assign dbr_d  = strr_d ? mem[rd_adr] : 32'h0;
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk_i) begin
    if (wr_en && rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem[wr_adr][8*b +: 8] <= i_dbw[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      strr_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbr_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      strr_q  <= strr_d;
      busy_q  <= busy_d;
      dbr_q   <= dbr_d;
    end
  end

  assign o_ack  = ack_q;
  assign o_strr = strr_q;
  assign o_dbr  = dbr_q;
  assign o_busy = busy_q;

endmodule
